// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial product per clock.
// Optional SEQ_SHIFT_ADD_MULTIPLIER_EARLY_DONE_EN finishes once the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_A+WIDTH_B-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH_B) + 1;
  localparam int W     = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [W-1:0]       acc;
  logic [W-1:0]       mcand;
  logic [WIDTH_B-1:0] mplier;
  logic [CNT_W-1:0]   cnt;
  logic               ready_r;
  logic [W-1:0]       acc_next;
  logic               last;

  always_comb begin
    acc_next = mplier[0] ? acc + mcand : acc;
`ifdef SEQ_SHIFT_ADD_MULTIPLIER_EARLY_DONE_EN
    last = (cnt == CNT_W'(WIDTH_B - 1)) || ((mplier >> 1) == '0);
`else
    last = (cnt == CNT_W'(WIDTH_B - 1));
`endif
  end

  // Registered idle flag is masked by rst so ready drops the moment reset is applied.
  assign ready = ready_r & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand   <= W'(a);
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            ready_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= acc_next;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: timeline model compared every cycle,
// plus directed literal checks and randomized operations/aborts.
module tb_seq_shift_add_multiplier;

  localparam int WA = 8;
  localparam int WB = 8;

`ifdef SEQ_SHIFT_ADD_MULTIPLIER_EARLY_DONE_EN
  localparam int LAT_0B = 4, LAT_FF = 8, LAT_A5 = 8, LAT_00 = 1, LAT_34 = 6, LAT_03 = 2;
  localparam int HELD_INTERVAL = 5;
`else
  localparam int LAT_0B = 8, LAT_FF = 8, LAT_A5 = 8, LAT_00 = 8, LAT_34 = 8, LAT_03 = 8;
  localparam int HELD_INTERVAL = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WA-1:0] a = '0;
  logic [WB-1:0] b = '0;
  logic          ready, busy, done;
  logic [15:0]   result;

  int n_checks = 0;
  int n_pass   = 0;

  seq_shift_add_multiplier #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Cycles of RUN for a given multiplier value.
  function automatic int lat_of(input logic [WB-1:0] bv);
    int l;
`ifdef SEQ_SHIFT_ADD_MULTIPLIER_EARLY_DONE_EN
    l = 1;
    for (int i = 0; i < WB; i++) if (bv[i]) l = i + 1;
`else
    l = WB;
`endif
    return l;
  endfunction

  // Timeline model: an accepted op is busy until its done cycle, then idle one cycle later.
  int          cyc = 0;
  int          t_done = 0;
  bit          m_valid = 0, m_busy = 0, m_done = 0;
  logic [15:0] m_result = '0, m_pend = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid  = 1;
      m_busy   = 0;
      m_done   = 0;
      m_result = '0;
    end else if (m_valid) begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          t_done = cyc + lat_of(b);
          m_pend = 16'(a) * 16'(b);
        end
      end else if (cyc == t_done) begin
        m_done   = 1;
        m_result = m_pend;
      end else if (cyc == t_done + 1) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready",  ready,  !m_busy && !rst);
      chk("busy",   busy,   m_busy);
      chk("done",   done,   m_done);
      chk("result", result, m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin tick(); n++; end
    chk("ready_wait", ready, 1);
  endtask

  task automatic run_op(input string name, input logic [WA-1:0] ta, input logic [WB-1:0] tb_v,
                        input logic [15:0] exp, input int exp_lat, input bit scramble);
    int n = 0;
    wait_ready();
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin a = '1; b = '1; end
    while (!done && n < 60) begin tick(); n++; end
    chk({"done_seen_", name}, done, 1);
    chk({"latency_", name}, n, exp_lat);
    chk({"result_", name}, result, exp);
    chk({"model_", name}, m_result, exp);
  endtask

  task automatic abort_op(input logic [WA-1:0] ta, input logic [WB-1:0] tb_v, input int k);
    bit saw = 0;
    wait_ready();
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (k) begin tick(); if (done) saw = 1; end
    rst = 1'b1;
    tick();
    if (done) saw = 1;
    rst = 1'b0;
    chk("abort_no_done", saw, 0);
    chk("abort_result", result, 0);
    tick();
    chk("abort_ready", ready, 1);
  endtask

  initial begin
    int first, second, gap, k;
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;

    // Reset held with a simultaneous start request that must be dropped.
    rst = 1'b1; start = 1'b1; a = 8'h05; b = 8'h05;
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_result", result, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", ready, 1);

    run_op("0d_0b", 8'h0D, 8'h0B, 16'h008F, LAT_0B, 0);
    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01, LAT_FF, 0);
    run_op("00_a5", 8'h00, 8'hA5, 16'h0000, LAT_A5, 0);
    run_op("5a_00", 8'h5A, 8'h00, 16'h0000, LAT_00, 0);

    // start held high: back-to-back ops, start ignored while busy.
    wait_ready();
    a = 8'h03; b = 8'h05; start = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
        chk("held_result", result, 16'h000F);
      end
    end
    start = 1'b0;
    chk("held_interval", second - first, HELD_INTERVAL);

    run_op("12_34_scr", 8'h12, 8'h34, 16'h03A8, LAT_34, 1);

    abort_op(8'h40, 8'h40, 3);
    run_op("02_03", 8'h02, 8'h03, 16'h0006, LAT_03, 0);

    for (int i = 0; i < 40; i++) begin
      ra = WA'($urandom);
      rb = WB'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, lat_of(rb) - 1);
        abort_op(ra, rb, k);
      end else begin
        run_op("rand", ra, rb, 16'(ra) * 16'(rb), lat_of(rb), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
